// File: rtl/ddr_word_dma_if.sv
// Bundle of the command, write-stream, read-stream, status and DDR word-port
// signals used by ddr_word_dma.
interface ddr_word_dma_if #(
    parameter int unsigned LEN_W = 16
);
    // Command channel
    logic             cmd_valid;
    logic             cmd_ready;
    logic             cmd_wr;
    logic [31:0]      cmd_addr;
    logic [LEN_W-1:0] cmd_len;

    // Write data stream into the sequencer
    logic             wr_valid;
    logic             wr_ready;
    logic [31:0]      wr_data;

    // Read data stream out of the sequencer
    logic             rd_valid;
    logic             rd_ready;
    logic [31:0]      rd_data;

    // Status
    logic             done;
    logic             busy;

    // Single-word DDR controller port
    logic [31:0]      ddr_addr;
    logic             ddr_en;
    logic             ddr_wr;
    logic [31:0]      ddr_wdata;
    logic [3:0]       ddr_mask;
    logic             ddr_rdy;
    logic [31:0]      ddr_rdata;
    logic             ddr_rd_vld;

    // Sequencer view: it masters the DDR port and serves the streams
    modport master (
        input  cmd_valid, cmd_wr, cmd_addr, cmd_len,
        input  wr_valid, wr_data,
        input  rd_ready,
        input  ddr_rdy, ddr_rdata, ddr_rd_vld,
        output cmd_ready, wr_ready, rd_valid, rd_data,
        output done, busy,
        output ddr_addr, ddr_en, ddr_wr, ddr_wdata, ddr_mask
    );

    // Environment view: command source, stream endpoints and DDR controller
    modport slave (
        output cmd_valid, cmd_wr, cmd_addr, cmd_len,
        output wr_valid, wr_data,
        output rd_ready,
        output ddr_rdy, ddr_rdata, ddr_rd_vld,
        input  cmd_ready, wr_ready, rd_valid, rd_data,
        input  done, busy,
        input  ddr_addr, ddr_en, ddr_wr, ddr_wdata, ddr_mask
    );
endinterface

// File: rtl/ddr_word_dma.sv
// Block-command sequencer for a single-word DDR controller port.
// Writes pull words from a valid/ready stream and issue one DDR write per word,
// enforcing an idle gap after each write since the controller reports no
// write completion. Reads issue one DDR read per word and hand each word to a
// valid/ready stream before the next read is issued. At most one DDR
// transaction is ever outstanding.
module ddr_word_dma #(
    parameter int unsigned LEN_W  = 16,
    parameter int unsigned WR_GAP = 16
) (
    input  logic           i_clk,
    input  logic           i_rst_n,
    ddr_word_dma_if.master bus
);

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned MASK_W = 4;
    localparam int unsigned GAP_W  = (WR_GAP < 1) ? 1 : $clog2(WR_GAP + 1);

    localparam logic [GAP_W-1:0]  GAP_LOAD   = GAP_W'(WR_GAP);
    localparam logic [ADDR_W-1:0] WORD_BYTES = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] WORD_ALIGN = ~ADDR_W'(3);
    localparam logic [MASK_W-1:0] FULL_MASK  = {MASK_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_LOAD,
        S_WR_ISSUE,
        S_WR_GAP,
        S_RD_ISSUE,
        S_RD_WAIT,
        S_RD_OUT,
        S_DONE
    } state_e;

    state_e             state_q,     state_d;
    logic [ADDR_W-1:0]  addr_q,      addr_d;
    logic [LEN_W-1:0]   remaining_q, remaining_d;
    logic [GAP_W-1:0]   gap_q,       gap_d;
    logic [DATA_W-1:0]  wdata_q,     wdata_d;
    logic [DATA_W-1:0]  rdata_q,     rdata_d;
    logic               rd_valid_q,  rd_valid_d;
    logic               ddr_wr_q,    ddr_wr_d;
    logic [MASK_W-1:0]  mask_q,      mask_d;
    logic               cmd_ready_q, cmd_ready_d;
    logic               busy_q,      busy_d;
    logic               wr_ready_q,  wr_ready_d;
    logic               done_q,      done_d;
    logic               issue_c;

    // A transaction is presented for exactly the cycle the controller is ready
    assign issue_c = ((state_q == S_WR_ISSUE) || (state_q == S_RD_ISSUE)) && bus.ddr_rdy;

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        gap_d       = gap_q;
        wdata_d     = wdata_q;
        rdata_d     = rdata_q;
        rd_valid_d  = rd_valid_q;
        ddr_wr_d    = ddr_wr_q;
        mask_d      = mask_q;

        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    addr_d      = bus.cmd_addr & WORD_ALIGN;
                    remaining_d = bus.cmd_len;
                    ddr_wr_d    = bus.cmd_wr;
                    mask_d      = FULL_MASK;
                    if (bus.cmd_len == '0) begin
                        state_d = S_DONE;
                    end else if (bus.cmd_wr) begin
                        state_d = S_WR_LOAD;
                    end else begin
                        state_d = S_RD_ISSUE;
                    end
                end
            end

            S_WR_LOAD: begin
                if (bus.wr_valid) begin
                    wdata_d = bus.wr_data;
                    state_d = S_WR_ISSUE;
                end
            end

            S_WR_ISSUE: begin
                if (issue_c) begin
                    if (remaining_q != '0) begin
                        remaining_d = remaining_q - LEN_W'(1);
                    end
                    gap_d   = GAP_LOAD;
                    state_d = S_WR_GAP;
                end
            end

            S_WR_GAP: begin
                if (gap_q == '0) begin
                    addr_d  = addr_q + WORD_BYTES;
                    state_d = (remaining_q == '0) ? S_DONE : S_WR_LOAD;
                end else begin
                    gap_d = gap_q - GAP_W'(1);
                end
            end

            S_RD_ISSUE: begin
                if (issue_c) begin
                    state_d = S_RD_WAIT;
                end
            end

            S_RD_WAIT: begin
                if (bus.ddr_rd_vld) begin
                    rdata_d    = bus.ddr_rdata;
                    rd_valid_d = 1'b1;
                    if (remaining_q != '0) begin
                        remaining_d = remaining_q - LEN_W'(1);
                    end
                    state_d = S_RD_OUT;
                end
            end

            S_RD_OUT: begin
                if (bus.rd_ready) begin
                    rd_valid_d = 1'b0;
                    addr_d     = addr_q + WORD_BYTES;
                    state_d    = (remaining_q == '0) ? S_DONE : S_RD_ISSUE;
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        cmd_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
        wr_ready_d  = (state_d == S_WR_LOAD);
        done_d      = (state_d == S_DONE);
    end

    // State, datapath and output registers; reset abandons any command
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            gap_q       <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            rd_valid_q  <= 1'b0;
            ddr_wr_q    <= 1'b0;
            mask_q      <= '0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            wr_ready_q  <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            gap_q       <= gap_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            rd_valid_q  <= rd_valid_d;
            ddr_wr_q    <= ddr_wr_d;
            mask_q      <= mask_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            wr_ready_q  <= wr_ready_d;
            done_q      <= done_d;
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.wr_ready  = wr_ready_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_data   = rdata_q;
    assign bus.done      = done_q;
    assign bus.busy      = busy_q;
    assign bus.ddr_addr  = addr_q;
    assign bus.ddr_en    = issue_c;
    assign bus.ddr_wr    = ddr_wr_q;
    assign bus.ddr_wdata = wdata_q;
    assign bus.ddr_mask  = mask_q;

endmodule

// File: tb/tb_ddr_word_dma.sv
// Bench for ddr_word_dma: directed scenarios plus randomized commands, checked
// against a transaction-level model of the expected DDR issues and read stream.
module tb_ddr_word_dma;

    localparam int unsigned LEN_W   = 16;
    localparam int unsigned WR_GAP  = 16;
    localparam int unsigned RSP_DLY = 3;

    logic i_clk;
    logic i_rst_n;

    ddr_word_dma_if #(.LEN_W(LEN_W)) bus ();

    ddr_word_dma #(.LEN_W(LEN_W), .WR_GAP(WR_GAP)) dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus)
    );

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] wdata;
        logic [3:0]  mask;
        int          cyc;
    } iss_t;

    // Owned by the main sequence
    int          n_tests = 0;
    int          n_fail  = 0;
    int          rdy_mode = 1;
    bit          wr_rand = 0;
    bit          rd_rand = 0;
    int          rd_hold = 0;
    int          hold_at = 0;
    int          rsp_dly = RSP_DLY;
    int          manual_req = 0;
    int          iss_base, got_base, done_base, b2b_base, lat_base;
    logic [31:0] data_q[$];

    // Owned by the environment process
    int          cyc = 0;
    iss_t        iss_q[$];
    logic [31:0] wr_q[$];
    logic [31:0] rsp_q[$];
    logic [31:0] got_q[$];
    int          hs_q[$];
    int          done_cnt = 0;
    int          done_cyc = -1;
    int          b2b_err = 0;
    int          lat_err = 0;
    int          manual_ack = 0;
    int          rsp_cnt = 0;
    int          valid_age = 0;
    bit          rsp_fired = 0;
    bit          rsp_prev = 0;
    bit          prev_en = 0;

    initial begin
        i_clk = 1'b0;
        forever #5 i_clk = ~i_clk;
    end

    always @(posedge i_clk) cyc <= cyc + 1;

    // Environment: DDR controller model, write source and read sink.
    // Inputs change on the falling edge, outputs are observed 2 time units later.
    initial begin
        bus.ddr_rdy    = 1'b1;
        bus.ddr_rd_vld = 1'b0;
        bus.ddr_rdata  = '0;
        bus.wr_valid   = 1'b0;
        bus.wr_data    = '0;
        bus.rd_ready   = 1'b0;
        forever begin
            @(negedge i_clk);
            bus.ddr_rd_vld = 1'b0;
            rsp_fired      = 1'b0;
            case (rdy_mode)
                0:       bus.ddr_rdy = 1'b0;
                1:       bus.ddr_rdy = 1'b1;
                default: bus.ddr_rdy = 1'($urandom_range(0, 1));
            endcase
            if (!i_rst_n) begin
                rsp_cnt      = 0;
                valid_age    = 0;
                bus.wr_valid = 1'b0;
                bus.rd_ready = 1'b0;
            end else begin
                if (manual_req != manual_ack) begin
                    manual_ack++;
                    bus.ddr_rd_vld = 1'b1;
                    bus.ddr_rdata  = 32'hDEAD_BEEF;
                end else if (rsp_cnt != 0) begin
                    rsp_cnt--;
                    if (rsp_cnt == 0) begin
                        bus.ddr_rd_vld = 1'b1;
                        bus.ddr_rdata  = (rsp_q.size() != 0) ? rsp_q.pop_front() : 32'hBAD0_BAD0;
                        rsp_fired      = 1'b1;
                    end
                end
                if (wr_q.size() != 0 && (!wr_rand || $urandom_range(0, 3) != 0)) begin
                    bus.wr_valid = 1'b1;
                    bus.wr_data  = wr_q[0];
                end else begin
                    bus.wr_valid = 1'b0;
                    bus.wr_data  = $urandom();
                end
                if (bus.rd_valid && got_q.size() == hold_at && valid_age < rd_hold)
                    bus.rd_ready = 1'b0;
                else if (rd_rand)
                    bus.rd_ready = 1'($urandom_range(0, 1));
                else
                    bus.rd_ready = 1'b1;
                valid_age = bus.rd_valid ? valid_age + 1 : 0;
            end
            #2;
            if (rsp_prev && !bus.rd_valid) lat_err++;
            if (bus.ddr_en) begin
                iss_t e;
                e.addr  = bus.ddr_addr;
                e.wr    = bus.ddr_wr;
                e.wdata = bus.ddr_wdata;
                e.mask  = bus.ddr_mask;
                e.cyc   = cyc;
                iss_q.push_back(e);
                if (prev_en) b2b_err++;
                if (!bus.ddr_wr) rsp_cnt = rsp_dly;
            end
            if (bus.wr_valid && bus.wr_ready && wr_q.size() != 0) void'(wr_q.pop_front());
            if (bus.rd_valid && bus.rd_ready) begin
                got_q.push_back(bus.rd_data);
                hs_q.push_back(cyc);
            end
            if (bus.done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            prev_en  = bus.ddr_en;
            rsp_prev = rsp_fired;
        end
    end

    task automatic tick();
        @(negedge i_clk);
        #3;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Present a command and return the cycle it was accepted in
    task automatic start_cmd(input bit wr, input logic [31:0] addr, input int len, output int acc);
        int k;
        iss_base  = iss_q.size();
        got_base  = got_q.size();
        hold_at   = got_base;
        done_base = done_cnt;
        b2b_base  = b2b_err;
        lat_base  = lat_err;
        foreach (data_q[i]) begin
            if (wr) wr_q.push_back(data_q[i]);
            else    rsp_q.push_back(data_q[i]);
        end
        bus.cmd_valid = 1'b1;
        bus.cmd_wr    = wr;
        bus.cmd_addr  = addr;
        bus.cmd_len   = LEN_W'(len);
        k = 0;
        while (!bus.cmd_ready && k < 50) begin
            tick();
            k++;
        end
        chk("cmd_accept", 32'(bus.cmd_ready), 32'd1);
        acc = cyc;
        tick();
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = $urandom();
    endtask

    // Wait for completion and compare everything observed with the model
    task automatic finish_cmd(input bit wr, input logic [31:0] addr, input int len,
                              input int acc, input bit rd_lat_exact);
        int k, n, ng;
        logic [31:0] exp_addr;
        iss_t e, p;
        k = 0;
        while (done_cnt == done_base && k < 400 + len * 80) begin
            tick();
            k++;
        end
        chk("done_count", 32'(done_cnt - done_base), 32'd1);
        tick();
        chk("busy_after_done", 32'(bus.busy), 32'd0);
        chk("cmd_ready_after_done", 32'(bus.cmd_ready), 32'd1);
        n = iss_q.size() - iss_base;
        chk("issue_count", 32'(n), 32'(len));
        for (int i = 0; i < n && i < len; i++) begin
            e = iss_q[iss_base + i];
            exp_addr = (addr & 32'hFFFF_FFFC) + 32'(4 * i);
            chk("issue_addr", e.addr, exp_addr);
            chk("issue_wr", 32'(e.wr), 32'(wr));
            chk("issue_mask", 32'(e.mask), 32'hF);
            if (wr) chk("issue_wdata", e.wdata, data_q[i]);
            if (i > 0) begin
                p = iss_q[iss_base + i - 1];
                if (wr) begin
                    chk("write_spacing", 32'(e.cyc - p.cyc >= int'(WR_GAP) + 2), 32'd1);
                end else if (hs_q.size() > got_base + i - 1) begin
                    chk("read_after_consume", 32'(e.cyc > hs_q[got_base + i - 1]), 32'd1);
                end
            end
        end
        if (n > 0) begin
            e = iss_q[iss_base];
            if (wr)                chk("first_write_latency", 32'(e.cyc - acc >= 2), 32'd1);
            else if (rd_lat_exact) chk("first_read_latency", 32'(e.cyc - acc), 32'd1);
        end
        if (!wr) begin
            ng = got_q.size() - got_base;
            chk("read_word_count", 32'(ng), 32'(len));
            for (int i = 0; i < ng && i < len; i++)
                chk("read_word_data", got_q[got_base + i], data_q[i]);
            if (len > 0 && ng >= len)
                chk("done_after_last_read", 32'(done_cyc), 32'(hs_q[got_base + len - 1] + 1));
            chk("rd_valid_latency", 32'(lat_err - lat_base), 32'd0);
        end
        chk("ddr_en_not_back_to_back", 32'(b2b_err - b2b_base), 32'd0);
    endtask

    initial begin
        int acc, r, k, len;
        bit wr;
        logic [31:0] addr;

        i_rst_n       = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_wr    = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;

        // Reset values
        tick(); tick();
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("rst_busy",      32'(bus.busy),      32'd0);
        chk("rst_done",      32'(bus.done),      32'd0);
        chk("rst_wr_ready",  32'(bus.wr_ready),  32'd0);
        chk("rst_rd_valid",  32'(bus.rd_valid),  32'd0);
        chk("rst_rd_data",   bus.rd_data,        32'd0);
        chk("rst_ddr_en",    32'(bus.ddr_en),    32'd0);
        chk("rst_ddr_addr",  bus.ddr_addr,       32'd0);
        chk("rst_ddr_wr",    32'(bus.ddr_wr),    32'd0);
        chk("rst_ddr_wdata", bus.ddr_wdata,      32'd0);
        chk("rst_ddr_mask",  32'(bus.ddr_mask),  32'd0);
        i_rst_n = 1'b1;
        tick(); tick();

        // Three-word write
        data_q = '{32'hA, 32'hB, 32'hC};
        start_cmd(1'b1, 32'h100, 3, acc);
        finish_cmd(1'b1, 32'h100, 3, acc, 1'b1);

        // Two-word read with a stalled consumer on the first word
        data_q  = '{32'h1111_1111, 32'h2222_2222};
        rd_hold = 5;
        start_cmd(1'b0, 32'h1F8, 2, acc);
        finish_cmd(1'b0, 32'h1F8, 2, acc, 1'b1);
        if (hs_q.size() > got_base && iss_q.size() > iss_base)
            chk("rd_hold_respected", 32'(hs_q[got_base] - iss_q[iss_base].cyc >= int'(RSP_DLY) + 6), 32'd1);
        rd_hold = 0;

        // Zero-length command
        data_q = {};
        start_cmd(1'($urandom_range(0, 1)), $urandom(), 0, acc);
        chk("len0_done_pulse", 32'(bus.done), 32'd1);
        chk("len0_cmd_ready_low", 32'(bus.cmd_ready), 32'd0);
        tick();
        chk("len0_cmd_ready_back", 32'(bus.cmd_ready), 32'd1);
        chk("len0_done_single", 32'(bus.done), 32'd0);
        chk("len0_done_cycle", 32'(done_cyc), 32'(acc + 1));
        finish_cmd(1'b1, 32'h0, 0, acc, 1'b1);

        // Controller not ready while a write is waiting to issue
        rdy_mode = 0;
        data_q   = '{$urandom()};
        start_cmd(1'b1, 32'h2000, 1, acc);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("ddr_en_held_low", 32'(bus.ddr_en), 32'd0);
        end
        chk("write_word_taken", 32'(wr_q.size()), 32'd0);
        r = cyc;
        rdy_mode = 1;
        finish_cmd(1'b1, 32'h2000, 1, acc, 1'b1);
        if (iss_q.size() > iss_base)
            chk("issue_on_first_ready", 32'(iss_q[iss_base].cyc), 32'(r + 1));

        // Unaligned base at the top of the address space wraps to zero
        data_q = '{$urandom(), $urandom()};
        start_cmd(1'b0, 32'hFFFF_FFFF, 2, acc);
        finish_cmd(1'b0, 32'hFFFF_FFFF, 2, acc, 1'b1);

        // Reset while waiting for read data, then a stray read-valid in idle
        rsp_dly = 30;
        data_q  = '{$urandom(), $urandom(), $urandom(), $urandom()};
        start_cmd(1'b0, 32'h400, 4, acc);
        k = 0;
        while (iss_q.size() == iss_base && k < 20) begin
            tick();
            k++;
        end
        chk("rst_test_issued", 32'(iss_q.size() - iss_base), 32'd1);
        tick(); tick();
        chk("rst_test_busy", 32'(bus.busy), 32'd1);
        i_rst_n = 1'b0;
        tick();
        chk("midrst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        chk("midrst_busy",      32'(bus.busy),      32'd0);
        chk("midrst_rd_valid",  32'(bus.rd_valid),  32'd0);
        chk("midrst_ddr_addr",  bus.ddr_addr,       32'd0);
        chk("midrst_ddr_mask",  32'(bus.ddr_mask),  32'd0);
        chk("midrst_done",      32'(bus.done),      32'd0);
        i_rst_n = 1'b1;
        tick();
        manual_req++;
        tick(); tick(); tick(); tick();
        chk("stray_vld_rd_valid",  32'(bus.rd_valid),           32'd0);
        chk("stray_vld_rd_data",   bus.rd_data,                 32'd0);
        chk("stray_vld_cmd_ready", 32'(bus.cmd_ready),          32'd1);
        chk("stray_vld_busy",      32'(bus.busy),               32'd0);
        chk("abandoned_no_done",   32'(done_cnt - done_base),   32'd0);
        chk("abandoned_no_issue",  32'(iss_q.size() - iss_base), 32'd1);
        rsp_q.delete();
        rsp_dly = RSP_DLY;

        // Randomized commands with random stalls on every interface
        wr_rand  = 1;
        rd_rand  = 1;
        rdy_mode = 2;
        for (int t = 0; t < 10; t++) begin
            wr      = 1'($urandom_range(0, 1));
            len     = $urandom_range(1, 4);
            addr    = ($urandom_range(0, 2) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom();
            rsp_dly = $urandom_range(1, 5);
            data_q  = {};
            for (int i = 0; i < len; i++) data_q.push_back($urandom());
            start_cmd(wr, addr, len, acc);
            finish_cmd(wr, addr, len, acc, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
